mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 34 +++
 rtl/mem_load_ext.sv | 27 ++
 rtl/mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared encodings for the memory controller.
//   op field layout: op[3] load/store, op[2] zero-extend, op[1:0] access size.
//   FSM state encoding, and the upper-halfword tag of the IO window.
package mem_ctrl_pkg;

   // op field
   localparam int         OP_LD_BIT = 3;   // 1 = load, 0 = store
   localparam int         OP_ZX_BIT = 2;   // 1 = zero-extend (loads only)
   localparam logic [1:0] SZ_BYTE   = 2'b00;
   localparam logic [1:0] SZ_HALF   = 2'b01;
   localparam logic [1:0] SZ_WORD   = 2'b10;

   // instruction fetch is handled as an unextended 4-byte load
   localparam logic [3:0] OP_FETCH  = 4'b1010;

   // FSM states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_READ   = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // stores whose addr[31:16] matches this go to the IO buffer
   localparam logic [15:0] IO_ADDR_HI = 16'h0003;

   // index of the last byte of an access of the given size
   function automatic logic [1:0] last_idx(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: last_idx = 2'd0;
         SZ_HALF: last_idx = 2'd1;
         default: last_idx = 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext -- combinational load-result extension.
//   raw : assembled little-endian bytes (only the low 1/2/4 bytes are meaningful)
//   op  : access op; size from op[1:0], zero-extend when op[2]
//   ext : sign- or zero-extended 32-bit result
module mem_load_ext
   import mem_ctrl_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [3:0]  op,
   output logic [31:0] ext
);

   logic sx;

   // sign-extension only makes sense for loads without the zero-extend bit
   assign sx = op[OP_LD_BIT] & ~op[OP_ZX_BIT];

   always_comb begin
      ext = raw;
      case (op[1:0])
         SZ_BYTE: ext = {{24{sx & raw[7]}},  raw[7:0]};
         SZ_HALF: ext = {{16{sx & raw[15]}}, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial RAM controller shared by the LSB and instruction fetch.
//   clk_in, rst_in (async, active low), rdy_in (global stall), clear_flag (flush)
//   LSB   : full_mem/addr/data/op in, mem_ready pulse + mem_val out
//   fetch : if_req/if_addr in, if_ready pulse + if_data out
//   RAM   : mem_a/mem_dout/mem_wr out, mem_din in (one-cycle read latency),
//           io_buffer_full stalls stores into the IO window
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear_flag,
   // LSB port
   input  logic        full_mem,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic [3:0]  op,
   output logic        mem_ready,
   output logic [31:0] mem_val,
   // fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_data,
   // RAM port
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   logic [1:0]  state;
   logic [1:0]  cnt;        // index of the byte currently on the bus
   logic [1:0]  cnt_nxt;
   logic [31:0] base;
   logic [31:0] st_data;
   logic [3:0]  cur_op;
   logic        is_fetch;
   logic        rd_last;    // all bytes sampled, result goes out next edge
   logic [31:0] rd_buf;
   logic [31:0] ext_val;
   logic        io_blk;
   logic        acc_io_blk;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         default: byte_sel = w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                            input logic [7:0] b);
      put_byte = w;
      case (i)
         2'd0:    put_byte[7:0]   = b;
         2'd1:    put_byte[15:8]  = b;
         2'd2:    put_byte[23:16] = b;
         default: put_byte[31:24] = b;
      endcase
   endfunction

   mem_load_ext u_ext (
      .raw (rd_buf),
      .op  (cur_op),
      .ext (ext_val)
   );

   assign cnt_nxt    = cnt + 2'd1;
   // in WRITE the latched base decides; at acceptance the incoming addr does
   assign io_blk     = (base[31:16] == IO_ADDR_HI) && io_buffer_full;
   assign acc_io_blk = (addr[31:16] == IO_ADDR_HI) && io_buffer_full;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= ST_IDLE;
         cnt       <= 2'd0;
         base      <= '0;
         st_data   <= '0;
         cur_op    <= '0;
         is_fetch  <= 1'b0;
         rd_last   <= 1'b0;
         rd_buf    <= '0;
         mem_ready <= 1'b0;
         mem_val   <= '0;
         if_ready  <= 1'b0;
         if_data   <= '0;
         mem_a     <= '0;
         mem_dout  <= '0;
         mem_wr    <= 1'b0;
      end else if (rdy_in) begin
         case (state)
            ST_IDLE: begin
               // a flush in the same cycle suppresses any new acceptance
               if (!clear_flag && (full_mem || if_req)) begin
                  cnt     <= 2'd0;
                  rd_last <= 1'b0;
                  rd_buf  <= '0;
                  if (full_mem) begin
                     base     <= addr;
                     st_data  <= data;
                     cur_op   <= op;
                     is_fetch <= 1'b0;
                     mem_a    <= addr;
                     if (op[OP_LD_BIT]) begin
                        state <= ST_READ;
                     end else begin
                        state    <= ST_WRITE;
                        mem_dout <= data[7:0];
                        mem_wr   <= ~acc_io_blk;
                     end
                  end else begin
                     base     <= if_addr;
                     cur_op   <= OP_FETCH;
                     is_fetch <= 1'b1;
                     mem_a    <= if_addr;
                     state    <= ST_READ;
                  end
               end
            end

            ST_READ: begin
               if (clear_flag) begin
                  state <= ST_IDLE;
                  mem_a <= '0;
               end else if (rd_last) begin
                  state <= ST_DONE;
                  mem_a <= '0;
                  if (is_fetch) begin
                     if_ready <= 1'b1;
                     if_data  <= rd_buf;
                  end else begin
                     mem_ready <= 1'b1;
                     mem_val   <= ext_val;
                  end
               end else begin
                  // mem_din carries the byte for the address presented last edge
                  rd_buf <= put_byte(rd_buf, cnt, mem_din);
                  if (cnt == last_idx(cur_op[1:0])) begin
                     rd_last <= 1'b1;
                  end else begin
                     cnt   <= cnt_nxt;
                     mem_a <= base + 32'(cnt_nxt);
                  end
               end
            end

            ST_WRITE: begin
               // mem_wr high means the byte on the bus was written this cycle;
               // low means it is still waiting on the IO buffer
               if (mem_wr) begin
                  if (cnt == last_idx(cur_op[1:0])) begin
                     state     <= ST_DONE;
                     mem_wr    <= 1'b0;
                     mem_a     <= '0;
                     mem_dout  <= '0;
                     mem_ready <= 1'b1;
                     mem_val   <= '0;
                  end else begin
                     cnt      <= cnt_nxt;
                     mem_a    <= base + 32'(cnt_nxt);
                     mem_dout <= byte_sel(st_data, cnt_nxt);
                     mem_wr   <= ~io_blk;
                  end
               end else begin
                  mem_wr <= ~io_blk;
               end
            end

            default: begin
               // DONE: one cycle, requests still held here are not taken
               state     <= ST_IDLE;
               mem_ready <= 1'b0;
               if_ready  <= 1'b0;
               cnt       <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_flag;
   logic        full_mem, if_req, io_buffer_full;
   logic [31:0] addr, data, if_addr;
   logic [3:0]  op;
   logic        mem_ready, if_ready, mem_wr;
   logic [31:0] mem_val, if_data, mem_a;
   logic [7:0]  mem_din, mem_dout;

   logic [7:0]  ram [0:4095];

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   // RAM model: combinational read, so the byte for the address registered at
   // edge E is what the controller samples at edge E+1
   assign mem_din = ram[mem_a[11:0]];

   mem_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
      .full_mem(full_mem), .addr(addr), .data(data), .op(op),
      .mem_ready(mem_ready), .mem_val(mem_val),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // edges until a ready pulse is seen (0 if none within the bound)
   task automatic wait_rdy(output int n);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (mem_ready || if_ready) begin
            n = i;
            break;
         end
      end
   endtask

   int n, pulses;

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h78; ram[12'h101] = 8'h56;
      ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
      ram[12'h020] = 8'h80;

      rst_in = 1'b0; rdy_in = 1'b1; clear_flag = 1'b0;
      full_mem = 1'b0; if_req = 1'b0; io_buffer_full = 1'b0;
      addr = '0; data = '0; op = '0; if_addr = '0;
      tick(); tick();
      chk("rst_mem_ready", {31'b0, mem_ready}, 0);
      chk("rst_if_ready",  {31'b0, if_ready}, 0);
      chk("rst_mem_wr",    {31'b0, mem_wr}, 0);
      chk("rst_mem_a",     mem_a, 0);
      chk("rst_mem_val",   mem_val, 0);
      chk("rst_dout",      {24'b0, mem_dout}, 0);
      rst_in = 1'b1;
      tick();

      // LW 0x100
      full_mem = 1'b1; addr = 32'h100; op = 4'b1010;
      tick();
      chk("lw_a0", mem_a, 32'h100);
      chk("lw_wr0", {31'b0, mem_wr}, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("lw_addr_step", mem_a, 32'h100 + k);
      end
      tick();
      chk("lw_not_yet", {31'b0, mem_ready}, 0);
      tick();
      chk("lw_ready_e5", {31'b0, mem_ready}, 1);
      chk("lw_val", mem_val, 32'h12345678);
      full_mem = 1'b0;
      tick();
      chk("lw_pulse_1cyc", {31'b0, mem_ready}, 0);
      chk("lw_idle_a", mem_a, 0);

      // LB sign-extend
      full_mem = 1'b1; addr = 32'h20; op = 4'b1000;
      tick();
      wait_rdy(n);
      chk("lb_lat", n, 2);
      chk("lb_val", mem_val, 32'hFFFFFF80);
      full_mem = 1'b0;
      tick();

      // LBU zero-extend
      full_mem = 1'b1; addr = 32'h20; op = 4'b1100;
      tick();
      wait_rdy(n);
      chk("lbu_lat", n, 2);
      chk("lbu_val", mem_val, 32'h00000080);
      full_mem = 1'b0;
      tick();

      // SH 0x40, request held through DONE
      full_mem = 1'b1; addr = 32'h40; data = 32'hAABBCCDD; op = 4'b0001;
      tick();
      chk("sh_wr0", {31'b0, mem_wr}, 1);
      chk("sh_a0", mem_a, 32'h40);
      chk("sh_d0", {24'b0, mem_dout}, 32'hDD);
      tick();
      chk("sh_wr1", {31'b0, mem_wr}, 1);
      chk("sh_a1", mem_a, 32'h41);
      chk("sh_d1", {24'b0, mem_dout}, 32'hCC);
      chk("sh_not_yet", {31'b0, mem_ready}, 0);
      tick();
      chk("sh_ready_e2", {31'b0, mem_ready}, 1);
      chk("sh_val0", mem_val, 0);
      chk("sh_wr_off", {31'b0, mem_wr}, 0);
      tick();
      chk("sh_no_reacc_wr", {31'b0, mem_wr}, 0);
      chk("sh_no_reacc_a", mem_a, 0);
      chk("sh_ready_drop", {31'b0, mem_ready}, 0);
      full_mem = 1'b0;
      tick();
      chk("sh_idle_wr", {31'b0, mem_wr}, 0);

      // LSB and fetch together: LSB first
      full_mem = 1'b1; addr = 32'h20; op = 4'b1100;
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      chk("pri_lsb_a", mem_a, 32'h20);
      wait_rdy(n);
      chk("pri_lsb_lat", n, 2);
      chk("pri_lsb_rdy", {31'b0, mem_ready}, 1);
      chk("pri_no_if", {31'b0, if_ready}, 0);
      full_mem = 1'b0;
      tick();
      tick();
      chk("pri_fetch_a", mem_a, 32'h100);
      wait_rdy(n);
      chk("pri_fetch_lat", n, 5);
      chk("pri_if_rdy", {31'b0, if_ready}, 1);
      chk("pri_if_data", if_data, 32'h12345678);
      if_req = 1'b0;
      tick();
      chk("pri_if_drop", {31'b0, if_ready}, 0);

      // SB into IO window with io_buffer_full for 3 cycles
      full_mem = 1'b1; addr = 32'h00030000; data = 32'h0000005A; op = 4'b0000;
      io_buffer_full = 1'b1;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (mem_wr) pulses++;
      end
      chk("io_hold_wr_low", pulses, 0);
      io_buffer_full = 1'b0;
      tick();
      chk("io_wr", {31'b0, mem_wr}, 1);
      chk("io_a", mem_a, 32'h00030000);
      chk("io_d", {24'b0, mem_dout}, 32'h5A);
      tick();
      chk("io_ready", {31'b0, mem_ready}, 1);
      chk("io_wr_off", {31'b0, mem_wr}, 0);
      full_mem = 1'b0;
      tick();

      // rdy_in low freezes an LB
      full_mem = 1'b1; addr = 32'h20; op = 4'b1000;
      tick();
      rdy_in = 1'b0;
      tick();
      chk("stall_a", mem_a, 32'h20);
      tick();
      chk("stall_no_rdy", {31'b0, mem_ready}, 0);
      rdy_in = 1'b1;
      wait_rdy(n);
      chk("stall_lat", n, 2);
      chk("stall_val", mem_val, 32'hFFFFFF80);
      full_mem = 1'b0;
      tick();

      // clear_flag during fetch
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      tick();
      chk("clr_a1", mem_a, 32'h101);
      clear_flag = 1'b1; if_req = 1'b0;
      tick();
      chk("clr_idle_a", mem_a, 0);
      clear_flag = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (if_ready || mem_ready) pulses++;
      end
      chk("clr_no_pulse", pulses, 0);

      // reset mid-LW
      full_mem = 1'b1; addr = 32'h100; op = 4'b1010;
      tick(); tick(); tick();
      #1 rst_in = 1'b0;
      #1;
      chk("rstm_a", mem_a, 0);
      chk("rstm_val", mem_val, 0);
      chk("rstm_wr", {31'b0, mem_wr}, 0);
      chk("rstm_rdy", {31'b0, mem_ready}, 0);
      chk("rstm_ifd", if_data, 0);
      full_mem = 1'b0;
      tick();
      rst_in = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (mem_ready || if_ready) pulses++;
      end
      chk("rstm_no_pulse", pulses, 0);
      chk("rstm_idle_a", mem_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
